// File: rtl/maxpool_27_3_16.sv
// maxpool_27_3_16: streaming 1-D max pool over non-overlapping windows of P samples.
// Results leave through a registered 2-entry FIFO whose head drives the y_* ports.
module maxpool_27_3_16 #(
  parameter int L = 27,
  parameter int P = 3,
  parameter int T = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  output logic                y_last,
  input  logic                y_ready
);
  localparam int NV = L / P;
  localparam int WW = P > 1 ? $clog2(P) : 1;
  localparam int VW = NV > 1 ? $clog2(NV) : 1;
  if (L % P != 0) begin : g_len_check
    $error("maxpool_27_3_16: L must be a multiple of P");
  end
  logic [WW-1:0]       win_q, win_d;
  logic [VW-1:0]       vec_q, vec_d;
  logic signed [T-1:0] max_q, max_d, hd_q, hd_d, sd_q, sd_d, pv;
  logic                hv_q, hv_d, hl_q, hl_d, sv_q, sv_d, sl_q, sl_d;
  logic                win_end, acc, push, pop, pl;
  assign win_end = win_q == WW'(P - 1);
  // Only a window-completing beat needs a free slot, so x_ready ignores y_ready.
  assign x_ready = !reset && !(win_end && hv_q && sv_q);
  assign acc     = x_valid && x_ready;
  assign push    = acc && win_end;
  assign pop     = hv_q && y_ready;
  assign pv      = x_data > max_q ? x_data : max_q;
  assign pl      = vec_q == VW'(NV - 1);
  assign y_data  = hd_q;
  assign y_valid = hv_q;
  assign y_last  = hl_q;
  always_comb begin
    win_d = acc ? (win_end ? '0 : win_q + 1'b1) : win_q;
    vec_d = push ? (pl ? '0 : vec_q + 1'b1) : vec_q;
    max_d = acc && (win_q == '0 || x_data > max_q) ? x_data : max_q;
    hv_d  = pop ? (sv_q || push) : (hv_q || push);
    hd_d  = pop && sv_q ? sd_q : ((pop || !hv_q) && push ? pv : hd_q);
    hl_d  = pop && sv_q ? sl_q : ((pop || !hv_q) && push ? pl : hl_q);
    sv_d  = pop ? (sv_q && push) : (sv_q || (hv_q && push));
    sd_d  = push ? pv : sd_q;
    sl_d  = push ? pl : sl_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
      vec_q <= '0;
      max_q <= '0;
      hd_q  <= '0;
      hv_q  <= 1'b0;
      hl_q  <= 1'b0;
      sd_q  <= '0;
      sv_q  <= 1'b0;
      sl_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      vec_q <= vec_d;
      max_q <= max_d;
      hd_q  <= hd_d;
      hv_q  <= hv_d;
      hl_q  <= hl_d;
      sd_q  <= sd_d;
      sv_q  <= sv_d;
      sl_q  <= sl_d;
    end
  end
endmodule

// File: tb/tb_maxpool_27_3_16.sv
// tb_maxpool_27_3_16: directed and random stimulus for maxpool_27_3_16 with a queue-based reference model.
module tb_maxpool_27_3_16;
  localparam int L = 27, P = 3, T = 16, NV = L / P;
  logic clk = 1'b0, reset = 1'b1, x_valid = 1'b0, y_ready = 1'b0;
  logic signed [T-1:0] x_data = '0;
  logic signed [T-1:0] y_data;
  logic x_ready, y_valid, y_last;
  int checks = 0, errors = 0, n_out = 0, n_last = 0, mcnt = 0, b_out, b_last;
  logic signed [T-1:0] win[$];
  logic signed [T-1:0] exp_d[$];
  logic exp_l[$];
  logic signed [T-1:0] hold_d;
  logic hold_l, stalled = 1'b0, done;
  always #5 clk = ~clk;
  maxpool_27_3_16 #(.L(L), .P(P), .T(T)) dut (
    .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic signed [T-1:0] v);
    logic r;
    x_valid = 1'b1;
    x_data = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = x_ready;
      @(posedge clk);
      #1;
      if (r) return;
    end
    chk("beat_timeout", 0, 1);
  endtask
  task automatic do_reset();
    x_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic settle();
    x_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask
  // Reference model: windows of accepted beats become expected results, popped in order.
  always @(posedge clk) begin
    logic signed [T-1:0] m;
    if (reset) begin
      win.delete();
      exp_d.delete();
      exp_l.delete();
      mcnt = 0;
      stalled = 1'b0;
    end else begin
      if (y_valid) begin
        if (stalled) begin
          chk("stall_data", y_data, hold_d);
          chk("stall_last", y_last, hold_l);
        end
        if (y_ready) begin
          if (exp_d.size() == 0) chk("pop_unexpected", 1, 0);
          else begin
            chk("out_data", y_data, exp_d.pop_front());
            chk("out_last", y_last, exp_l.pop_front());
          end
          n_out++;
          if (y_last) n_last++;
        end
        stalled = !y_ready;
        hold_d = y_data;
        hold_l = y_last;
      end else stalled = 1'b0;
      if (x_valid && x_ready) begin
        win.push_back(x_data);
        if (win.size() == P) begin
          m = win[0];
          for (int i = 1; i < P; i++) if (win[i] > m) m = win[i];
          exp_d.push_back(m);
          exp_l.push_back(mcnt == NV - 1);
          mcnt = (mcnt + 1) % NV;
          win.delete();
        end
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1);
  end
  initial begin
    logic signed [T-1:0] sv[9];
    logic signed [T-1:0] se[3];
    sv = '{-5, -3, -9, 7, 7, 2, 0, -1, 0};
    se = '{-3, 7, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_last", y_last, 0);
    chk("rst_x_ready", x_ready, 0);
    reset = 1'b0;
    #1;
    chk("idle_x_ready", x_ready, 1);
    // Streaming 0..26
    y_ready = 1'b1;
    b_out = n_out;
    b_last = n_last;
    for (int i = 0; i < L; i++) begin
      beat(T'(i));
      if (i % P == P - 1) begin
        chk("stream_valid", y_valid, 1);
        chk("stream_data", y_data, i);
        chk("stream_last", y_last, i == L - 1);
      end
    end
    settle();
    chk("stream_count", n_out - b_out, NV);
    chk("stream_lasts", n_last - b_last, 1);
    // Signed values and ties
    do_reset();
    for (int i = 0; i < 9; i++) begin
      beat(sv[i]);
      if (i % P == P - 1) chk("signed_data", y_data, se[i / P]);
    end
    settle();
    // Backpressure
    do_reset();
    y_ready = 1'b0;
    b_out = n_out;
    for (int i = 1; i <= 8; i++) beat(T'(i));
    x_data = 16'sd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_x_ready", x_ready, 0);
      chk("bp_head", y_data, 3);
      chk("bp_valid", y_valid, 1);
    end
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    beat(16'sd9);
    settle();
    chk("bp_drain_count", n_out - b_out, 3);
    // Reset mid-vector with one result queued
    do_reset();
    y_ready = 1'b0;
    for (int i = 10; i <= 13; i++) beat(T'(i));
    x_valid = 1'b0;
    chk("mid_queued", y_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_valid", y_valid, 0);
    chk("mid_rst_data", y_data, 0);
    y_ready = 1'b1;
    b_out = n_out;
    b_last = n_last;
    for (int i = 0; i < L; i++) beat(T'((i * 5) % 11 - 5));
    settle();
    chk("mid_count", n_out - b_out, NV);
    chk("mid_lasts", n_last - b_last, 1);
    // Back-to-back vectors
    b_out = n_out;
    b_last = n_last;
    for (int i = 0; i < 2 * L; i++) begin
      beat(T'(100 - i));
      if (i % P == P - 1) chk("b2b_last", y_last, i == L - 1 || i == 2 * L - 1);
    end
    settle();
    chk("b2b_count", n_out - b_out, 2 * NV);
    chk("b2b_lasts", n_last - b_last, 2);
    // Random valid/ready
    b_out = n_out;
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 300; v++)
          for (int i = 0; i < L; i++) begin
            if ($urandom_range(0, 2) == 0) begin
              x_valid = 1'b0;
              @(posedge clk);
              #1;
            end
            beat(T'($urandom));
          end
        x_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          y_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    y_ready = 1'b1;
    settle();
    chk("rand_count", n_out - b_out, 300 * NV);
    chk("rand_empty", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
